sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port SRAM (32-bit, byte strobes, 1-cycle read latency) between two requesters.
- Port 0 is the high-priority CPU-side memory interface. Port 1 is a lower-priority DMA or initialisation engine.
- Port 0 normally wins every conflict. A starvation guard gives port 1 a slot after a bounded wait.
- Sits between the requesters' standard memory interfaces and the SRAM macro. Routes read data back to the requester that issued the read.

Parameters:
AW, 14, word-address width of memory and both ports
STARVE_LIM, 8, consecutive cycles port 1 may be denied before it is forced to win; 0 = pure fixed priority (guard disabled)

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
clken  input  1  clock enable, shared with the SRAM
pN_address  input  AW  port N word address (N = 0,1)
pN_write  input  1  port N write request
pN_read  input  1  port N read request
pN_wdata  input  32  port N write data, same cycle as pN_write
pN_wstrobe  input  4  port N byte write strobes
pN_ready  output  1  port N request accepted this cycle
pN_rdata  output  32  port N read data
pN_rvalid  output  1  pN_rdata valid, one cycle after accepted read
m_address  output  AW  SRAM word address
m_write  output  1  SRAM write
m_wdata  output  32  SRAM write data
m_wstrobe  output  4  SRAM byte strobes
m_read  output  1  SRAM read
m_rdata  input  32  SRAM read data, valid cycle after m_read

Behaviour:
- Request: reqN = pN_write | pN_read. If both pN_write and pN_read are high on one port, the write is performed and the read is dropped (no rvalid).
- Grant is combinational, same cycle. At most one grant per cycle. No grant when clken=0.
- Grant rule (clken=1):
  - If req1 and starve_cnt == STARVE_LIM and STARVE_LIM != 0, grant port 1.
  - Else if req0, grant port 0.
  - Else if req1, grant port 1.
- pN_ready = ~reqN | grantN.
  - An idle port sees ready=1.
  - While ready=0 the requester holds address, control, wdata and strobes stable.
  - When clken=0, pN_ready = ~reqN.
- Memory mux:
  - The granted port drives m_address, m_write, m_read, m_wdata and m_wstrobe.
  - m_read = granted read & ~granted write.
  - No grant: all m_* outputs are 0.
- starve_cnt: width clog2(STARVE_LIM+1), minimum 1 bit. Updates only on clken=1.
  - Reset to 0 when req1=0 or grant1=1.
  - Otherwise increment, saturating at STARVE_LIM.
  - Port 1 therefore waits at most STARVE_LIM cycles.
  - The cycle after a forced port-1 win, port 0 again has priority.
- Read return, registered on clken=1:
  - rvalidN_q <= grantN & m_read.
  - pN_rvalid = rvalidN_q.
  - pN_rdata = m_rdata when pN_rvalid, else 32'h0.
  - Return latency is exactly 1 enabled cycle. A read and a new request may overlap (back-to-back reads from either port, full throughput).
- clken=0: all registers hold. rvalid and rdata stay presented until the next enabled cycle.
- Reset (synchronous):
  - Clears starve_cnt and both rvalid registers. pN_rvalid=0 and pN_rdata=0 in the following cycle.
  - m_* outputs are 0 while reset is high.
  - pN_ready = ~reqN while reset is high.
  - A read in flight when reset asserts is discarded, with no rvalid.
- Write-then-read to the same address from different ports: ordering follows grant order. There is no forwarding; the SRAM provides coherence.

Test Plan:
- Port 0 only: write 0x12345678, strobes 4'hF to addr 5, then read addr 5. Required: p0_ready=1 both cycles, m_write then m_read on addr 5, p0_rvalid=1 with p0_rdata=0x12345678 next cycle, p1_rvalid=0.
- Port 1 only: write byte 0xAB, strobes 4'b0100 to addr 3. Required: m_wstrobe=4'b0100, m_wdata=p1_wdata, p1_ready=1 same cycle.
- Conflict, STARVE_LIM=8: both ports request continuously. Required: port 0 granted 8 cycles with p1_ready=0, port 1 granted in cycle 9 with p0_ready=0, and the pattern repeats.
- STARVE_LIM=0 with continuous port 0 requests. Required: p1_ready stays 0 indefinitely. Release port 0 and port 1 is granted the same cycle.
- Interleaved reads p0 addr 1 / p1 addr 2 / p0 addr 3 on consecutive cycles. Required: rvalid pulses on p0, p1, p0 respectively, one cycle after each grant, each carrying the matching data.
- clken low for 3 cycles after a read grant; separately, reset asserted during a read. Required: rvalid held through the 3 stalled cycles; reset gives rvalid=0, starve_cnt=0, m_*=0.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Requester-side and SRAM-side signals of the two-port SRAM arbiter.
// The slave modport is the arbiter, master is the requester pair, sram is the macro.
interface sram_port_arbiter_if #(
  parameter int AW = 14
);
  logic [AW-1:0] p0_address;
  logic          p0_write;
  logic          p0_read;
  logic [31:0]   p0_wdata;
  logic [3:0]    p0_wstrobe;
  logic          p0_ready;
  logic [31:0]   p0_rdata;
  logic          p0_rvalid;

  logic [AW-1:0] p1_address;
  logic          p1_write;
  logic          p1_read;
  logic [31:0]   p1_wdata;
  logic [3:0]    p1_wstrobe;
  logic          p1_ready;
  logic [31:0]   p1_rdata;
  logic          p1_rvalid;

  logic [AW-1:0] m_address;
  logic          m_write;
  logic [31:0]   m_wdata;
  logic [3:0]    m_wstrobe;
  logic          m_read;
  logic [31:0]   m_rdata;

  modport slave (
    input  p0_address, p0_write, p0_read, p0_wdata, p0_wstrobe,
    output p0_ready, p0_rdata, p0_rvalid,
    input  p1_address, p1_write, p1_read, p1_wdata, p1_wstrobe,
    output p1_ready, p1_rdata, p1_rvalid,
    output m_address, m_write, m_wdata, m_wstrobe, m_read,
    input  m_rdata
  );

  modport master (
    output p0_address, p0_write, p0_read, p0_wdata, p0_wstrobe,
    input  p0_ready, p0_rdata, p0_rvalid,
    output p1_address, p1_write, p1_read, p1_wdata, p1_wstrobe,
    input  p1_ready, p1_rdata, p1_rvalid
  );

  modport sram (
    input  m_address, m_write, m_wdata, m_wstrobe, m_read,
    output m_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between two requesters: same-cycle grant, read data one enabled cycle later.
// Port 0 wins conflicts; a denied port 1 sees ready=0 and is forced through after STARVE_LIM waits.
module sram_port_arbiter #(
  parameter int AW         = 14,
  parameter int STARVE_LIM = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clken,
  sram_port_arbiter_if.slave bus
);
  localparam int            CW  = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  logic          req0;
  logic          req1;
  logic          force1;
  logic          grant0;
  logic          grant1;

  logic [AW-1:0] m_address_c;
  logic          m_write_c;
  logic          m_read_c;
  logic [31:0]   m_wdata_c;
  logic [3:0]    m_wstrobe_c;

  logic [CW-1:0] starve_cnt_q;
  logic [CW-1:0] starve_cnt_d;
  logic          rvalid0_q;
  logic          rvalid0_d;
  logic          rvalid1_q;
  logic          rvalid1_d;

  always_comb begin
    req0   = bus.p0_write | bus.p0_read;
    req1   = bus.p1_write | bus.p1_read;
    force1 = (STARVE_LIM != 0) && req1 && (starve_cnt_q == LIM);

    grant0 = 1'b0;
    grant1 = 1'b0;
    if (clken && !reset) begin
      if (force1) begin
        grant1 = 1'b1;
      end else if (req0) begin
        grant0 = 1'b1;
      end else if (req1) begin
        grant1 = 1'b1;
      end
    end

    m_address_c = '0;
    m_write_c   = 1'b0;
    m_read_c    = 1'b0;
    m_wdata_c   = '0;
    m_wstrobe_c = '0;
    if (grant0) begin
      m_address_c = bus.p0_address;
      m_write_c   = bus.p0_write;
      m_read_c    = bus.p0_read & ~bus.p0_write;
      m_wdata_c   = bus.p0_wdata;
      m_wstrobe_c = bus.p0_wstrobe;
    end else if (grant1) begin
      m_address_c = bus.p1_address;
      m_write_c   = bus.p1_write;
      m_read_c    = bus.p1_read & ~bus.p1_write;
      m_wdata_c   = bus.p1_wdata;
      m_wstrobe_c = bus.p1_wstrobe;
    end

    // Everything holds while the clock enable is low, so a returned read stays presented.
    starve_cnt_d = starve_cnt_q;
    rvalid0_d    = rvalid0_q;
    rvalid1_d    = rvalid1_q;
    if (clken) begin
      if (!req1 || grant1) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != LIM) begin
        starve_cnt_d = starve_cnt_q + CW'(1);
      end
      rvalid0_d = grant0 & m_read_c;
      rvalid1_d = grant1 & m_read_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  assign bus.p0_ready  = ~req0 | grant0;
  assign bus.p1_ready  = ~req1 | grant1;
  assign bus.p0_rvalid = rvalid0_q;
  assign bus.p1_rvalid = rvalid1_q;
  assign bus.p0_rdata  = rvalid0_q ? bus.m_rdata : 32'h0;
  assign bus.p1_rdata  = rvalid1_q ? bus.m_rdata : 32'h0;

  assign bus.m_address = m_address_c;
  assign bus.m_write   = m_write_c;
  assign bus.m_read    = m_read_c;
  assign bus.m_wdata   = m_wdata_c;
  assign bus.m_wstrobe = m_wstrobe_c;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: instance A (STARVE_LIM=8) on an SRAM model, instance B (STARVE_LIM=0).
// Read data is checked by a scoreboard monitor; grant and memory-bus values by directed checks.
module tb_sram_port_arbiter;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic reset;
  logic clken;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.AW(AW)) a_if ();
  sram_port_arbiter_if #(.AW(AW)) b_if ();

  sram_port_arbiter #(.AW(AW), .STARVE_LIM(8)) u_dut_a (
    .clk(clk), .reset(reset), .clken(clken), .bus(a_if)
  );
  sram_port_arbiter #(.AW(AW), .STARVE_LIM(0)) u_dut_b (
    .clk(clk), .reset(reset), .clken(clken), .bus(b_if)
  );

  // SRAM model for instance A; instance B never reads, so its data bus is a marker.
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] sram_rdata = 32'h0;
  assign a_if.m_rdata = sram_rdata;
  assign b_if.m_rdata = 32'hDEAD_BEEF;

  initial for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;

  always @(posedge clk) begin
    if (clken) begin
      if (a_if.m_write)
        for (int b = 0; b < 4; b++)
          if (a_if.m_wstrobe[b]) mem[a_if.m_address][8*b +: 8] <= a_if.m_wdata[8*b +: 8];
      if (a_if.m_read) sram_rdata <= mem[a_if.m_address];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: k = 0/1 instance A port 0/1, k = 2/3 instance B port 0/1.
  logic [31:0] exp_q [4][$];
  logic [31:0] last_d [4];
  logic        held_v [4];
  logic        en_last = 1'b0;

  initial for (int k = 0; k < 4; k++) begin
    last_d[k] = 32'h0;
    held_v[k] = 1'b0;
  end

  always @(posedge clk) en_last <= clken;

  task automatic mon(input int k, input logic v, input logic [31:0] d);
    logic [31:0] e;
    if (en_last) begin
      if (v) begin
        if (exp_q[k].size() == 0) begin
          chk($sformatf("rvalid_unexpected_%0d", k), {63'h0, v}, 64'h0);
          last_d[k] = d;
        end else begin
          e = exp_q[k].pop_front();
          chk($sformatf("rdata_%0d", k), {32'h0, d}, {32'h0, e});
          last_d[k] = e;
        end
      end else begin
        chk($sformatf("rdata_idle_%0d", k), {32'h0, d}, 64'h0);
      end
      held_v[k] = v;
    end else begin
      chk($sformatf("rvalid_hold_%0d", k), {63'h0, v}, {63'h0, held_v[k]});
      chk($sformatf("rdata_hold_%0d", k), {32'h0, d}, {32'h0, (held_v[k] ? last_d[k] : 32'h0)});
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_if.p0_rvalid, a_if.p0_rdata);
    mon(1, a_if.p1_rvalid, a_if.p1_rdata);
    mon(2, b_if.p0_rvalid, b_if.p0_rdata);
    mon(3, b_if.p1_rvalid, b_if.p1_rdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drv0(input logic wr, input logic rd, input logic [AW-1:0] ad,
                      input logic [31:0] wd, input logic [3:0] st);
    a_if.p0_write = wr; a_if.p0_read = rd; a_if.p0_address = ad;
    a_if.p0_wdata = wd; a_if.p0_wstrobe = st;
  endtask

  task automatic drv1(input logic wr, input logic rd, input logic [AW-1:0] ad,
                      input logic [31:0] wd, input logic [3:0] st);
    a_if.p1_write = wr; a_if.p1_read = rd; a_if.p1_address = ad;
    a_if.p1_wdata = wd; a_if.p1_wstrobe = st;
  endtask

  task automatic idle_b();
    b_if.p0_write = 1'b0; b_if.p0_read = 1'b0; b_if.p0_address = '0;
    b_if.p0_wdata = '0; b_if.p0_wstrobe = '0;
    b_if.p1_write = 1'b0; b_if.p1_read = 1'b0; b_if.p1_address = '0;
    b_if.p1_wdata = '0; b_if.p1_wstrobe = '0;
  endtask

  function automatic logic [63:0] mexp(input logic w, input logic r, input logic [AW-1:0] ad,
                                       input logic [3:0] st, input logic [31:0] wd);
    return {12'h0, w, r, ad, st, wd};
  endfunction

  function automatic logic [63:0] mbus_a();
    return {12'h0, a_if.m_write, a_if.m_read, a_if.m_address, a_if.m_wstrobe, a_if.m_wdata};
  endfunction

  // Both ports write continuously; port 1 is expected every ninth cycle.
  task automatic conflict(input int n, input string tag);
    logic g1;
    for (int i = 0; i < n; i++) begin
      step();
      drv0(1'b1, 1'b0, 14'd100, 32'hA0A0_A0A0, 4'hF);
      drv1(1'b1, 1'b0, 14'd200, 32'hB1B1_B1B1, 4'hF);
      sample();
      g1 = (i % 9 == 8);
      chk({tag, "_p0_ready"}, {63'h0, a_if.p0_ready}, {63'h0, !g1});
      chk({tag, "_p1_ready"}, {63'h0, a_if.p1_ready}, {63'h0, g1});
      chk({tag, "_m_bus"}, mbus_a(),
          g1 ? mexp(1'b1, 1'b0, 14'd200, 4'hF, 32'hB1B1_B1B1)
             : mexp(1'b1, 1'b0, 14'd100, 4'hF, 32'hA0A0_A0A0));
    end
  endtask

  initial begin
    reset = 1'b1;
    clken = 1'b1;
    drv0(1'b0, 1'b0, '0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0, '0);
    idle_b();

    sample();
    chk("rst_p0_ready", {63'h0, a_if.p0_ready}, 64'h1);
    chk("rst_p1_ready", {63'h0, a_if.p1_ready}, 64'h1);
    chk("rst_m_bus", mbus_a(), 64'h0);

    // Port 0 alone: write then read addr 5
    step(); reset = 1'b0;
    drv0(1'b1, 1'b0, 14'd5, 32'h1234_5678, 4'hF);
    sample();
    chk("p0_wr_ready", {63'h0, a_if.p0_ready}, 64'h1);
    chk("p0_wr_m_bus", mbus_a(), mexp(1'b1, 1'b0, 14'd5, 4'hF, 32'h1234_5678));
    step(); drv0(1'b0, 1'b1, 14'd5, 32'h0, 4'h0);
    sample();
    chk("p0_rd_ready", {63'h0, a_if.p0_ready}, 64'h1);
    chk("p0_rd_m_bus", mbus_a(), mexp(1'b0, 1'b1, 14'd5, 4'h0, 32'h0));
    exp_q[0].push_back(32'h1234_5678);
    step(); drv0(1'b0, 1'b0, '0, '0, '0);
    sample();
    chk("idle_m_bus", mbus_a(), 64'h0);

    // Port 1 alone: single-byte write then read back
    step(); drv1(1'b1, 1'b0, 14'd3, 32'h00AB_0000, 4'b0100);
    sample();
    chk("p1_wr_ready", {63'h0, a_if.p1_ready}, 64'h1);
    chk("p1_wr_m_bus", mbus_a(), mexp(1'b1, 1'b0, 14'd3, 4'b0100, 32'h00AB_0000));
    step(); drv1(1'b0, 1'b1, 14'd3, 32'h0, 4'h0);
    sample();
    chk("p1_rd_m_bus", mbus_a(), mexp(1'b0, 1'b1, 14'd3, 4'h0, 32'h0));
    exp_q[1].push_back(32'h00AB_0000);

    // Write and read together: write wins, no read return
    step(); drv1(1'b0, 1'b0, '0, '0, '0);
    drv0(1'b1, 1'b1, 14'd7, 32'hCAFE_F00D, 4'hF);
    sample();
    chk("wr_rd_m_bus", mbus_a(), mexp(1'b1, 1'b0, 14'd7, 4'hF, 32'hCAFE_F00D));

    // Preload addresses 1..3
    step(); drv0(1'b1, 1'b0, 14'd1, 32'h1111_1111, 4'hF); sample();
    step(); drv0(1'b0, 1'b0, '0, '0, '0);
    drv1(1'b1, 1'b0, 14'd2, 32'h2222_2222, 4'hF); sample();
    chk("pre2_m_bus", mbus_a(), mexp(1'b1, 1'b0, 14'd2, 4'hF, 32'h2222_2222));
    step(); drv1(1'b0, 1'b0, '0, '0, '0);
    drv0(1'b1, 1'b0, 14'd3, 32'h3333_3333, 4'hF); sample();

    // Interleaved reads p0/p1/p0, then back-to-back p0 reads
    step(); drv0(1'b0, 1'b1, 14'd1, 32'h0, 4'h0); sample();
    chk("il0_m_bus", mbus_a(), mexp(1'b0, 1'b1, 14'd1, 4'h0, 32'h0));
    exp_q[0].push_back(32'h1111_1111);
    step(); drv0(1'b0, 1'b0, '0, '0, '0);
    drv1(1'b0, 1'b1, 14'd2, 32'h0, 4'h0); sample();
    chk("il1_m_bus", mbus_a(), mexp(1'b0, 1'b1, 14'd2, 4'h0, 32'h0));
    exp_q[1].push_back(32'h2222_2222);
    step(); drv1(1'b0, 1'b0, '0, '0, '0);
    drv0(1'b0, 1'b1, 14'd3, 32'h0, 4'h0); sample();
    chk("il2_m_bus", mbus_a(), mexp(1'b0, 1'b1, 14'd3, 4'h0, 32'h0));
    exp_q[0].push_back(32'h3333_3333);
    step(); drv0(1'b0, 1'b1, 14'd5, 32'h0, 4'h0); sample();
    exp_q[0].push_back(32'h1234_5678);
    step(); drv0(1'b0, 1'b1, 14'd7, 32'h0, 4'h0); sample();
    exp_q[0].push_back(32'hCAFE_F00D);
    step(); drv0(1'b0, 1'b0, '0, '0, '0); sample();

    // Starvation guard: two full 9-cycle rounds
    conflict(18, "conf");
    step(); drv0(1'b0, 1'b0, '0, '0, '0); drv1(1'b0, 1'b0, '0, '0, '0); sample();

    // Clock enable low for 3 cycles right after a read grant
    step(); drv0(1'b0, 1'b1, 14'd5, 32'h0, 4'h0); sample();
    exp_q[0].push_back(32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      step(); clken = 1'b0; drv0(1'b0, 1'b1, 14'd3, 32'h0, 4'h0);
      sample();
      chk("stall_p0_ready", {63'h0, a_if.p0_ready}, 64'h0);
      chk("stall_p1_ready", {63'h0, a_if.p1_ready}, 64'h1);
      chk("stall_m_bus", mbus_a(), 64'h0);
    end
    step(); clken = 1'b1; sample();
    chk("resume_p0_ready", {63'h0, a_if.p0_ready}, 64'h1);
    chk("resume_m_bus", mbus_a(), mexp(1'b0, 1'b1, 14'd3, 4'h0, 32'h0));
    exp_q[0].push_back(32'h3333_3333);
    step(); drv0(1'b0, 1'b0, '0, '0, '0); sample();

    // Build up starvation, then reset with a read request: nothing granted, counter cleared
    conflict(5, "pre_rst");
    step(); reset = 1'b1; drv0(1'b0, 1'b1, 14'd5, 32'h0, 4'h0);
    sample();
    chk("rst_rd_p0_ready", {63'h0, a_if.p0_ready}, 64'h0);
    chk("rst_rd_p1_ready", {63'h0, a_if.p1_ready}, 64'h0);
    chk("rst_rd_m_bus", mbus_a(), 64'h0);
    step(); reset = 1'b0;
    drv0(1'b0, 1'b0, '0, '0, '0); drv1(1'b0, 1'b0, '0, '0, '0);
    sample();
    chk("post_rst_p0_rvalid", {63'h0, a_if.p0_rvalid}, 64'h0);
    conflict(9, "post_rst");
    step(); drv0(1'b0, 1'b0, '0, '0, '0); drv1(1'b0, 1'b0, '0, '0, '0); sample();

    // Guard disabled: port 1 starves until port 0 lets go
    for (int i = 0; i < 20; i++) begin
      step();
      b_if.p0_write = 1'b1; b_if.p0_address = 14'd10; b_if.p0_wdata = 32'h0A0A_0A0A; b_if.p0_wstrobe = 4'hF;
      b_if.p1_write = 1'b1; b_if.p1_address = 14'd20; b_if.p1_wdata = 32'h1414_1414; b_if.p1_wstrobe = 4'hF;
      sample();
      chk("nolim_p0_ready", {63'h0, b_if.p0_ready}, 64'h1);
      chk("nolim_p1_ready", {63'h0, b_if.p1_ready}, 64'h0);
    end
    step(); b_if.p0_write = 1'b0; sample();
    chk("nolim_release_p1_ready", {63'h0, b_if.p1_ready}, 64'h1);
    chk("nolim_release_m_addr", {50'h0, b_if.m_address}, 64'd20);
    chk("nolim_release_m_write", {63'h0, b_if.m_write}, 64'h1);
    step(); idle_b(); sample();
    repeat (2) begin step(); sample(); end

    for (int k = 0; k < 4; k++)
      chk($sformatf("sb_drained_%0d", k), 64'(exp_q[k].size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
